// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin sequencer for a bank of HC-SR04 sonar drivers.
// Fires one transducer at a time and waits for its ready edge. It then captures
// the 8-bit distance into a per-channel register. A guard gap follows every shot
// to stop acoustic crosstalk. A per-shot timeout handles dead or blocked sensors.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   enable       level, continuous sweeping while high
//   start        pulse, runs one sweep when idle and enable is low
//   measure      one-hot 1-cycle trigger to driver[i]
//   ready        per-driver ready level (sticky until re-triggered)
//   distance     driver[i] distance on [8i+7:8i]
//   dist_out     captured distance per channel (8'hFF after a timeout)
//   valid        channel holds a fresh good sample
//   timeout      channel's last shot timed out
//   frame_done   1-cycle pulse when the last channel of a sweep completes
//   busy         scheduler is not idle
module sonar_scheduler #(
    parameter int unsigned freq       = 50_000_000,
    parameter int unsigned N_SONARS   = 4,
    parameter int unsigned GAP_MS     = 60,
    parameter int unsigned TIMEOUT_MS = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    start,
    output logic [N_SONARS-1:0]     measure,
    input  logic [N_SONARS-1:0]     ready,
    input  logic [N_SONARS*8-1:0]   distance,
    output logic [N_SONARS*8-1:0]   dist_out,
    output logic [N_SONARS-1:0]     valid,
    output logic [N_SONARS-1:0]     timeout,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int unsigned GAP_CYC = freq / 1000 * GAP_MS;
    localparam int unsigned TO_CYC  = freq / 1000 * TIMEOUT_MS;
    localparam int unsigned CH_W    = (N_SONARS > 1) ? $clog2(N_SONARS) : 1;

    localparam logic [31:0]     GAP_LAST = 32'(GAP_CYC - 1);
    localparam logic [31:0]     TO_LAST  = 32'(TO_CYC - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_SONARS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIRE     = 3'd1,
        S_WAIT_CLR = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CH_W-1:0]        r_ch;
    logic [CH_W-1:0]        w_ch_nxt;
    logic [31:0]            r_timer;
    logic [31:0]            w_timer_nxt;

    logic [N_SONARS-1:0]    r_measure;
    logic [N_SONARS*8-1:0]  r_dist_out;
    logic [N_SONARS-1:0]    r_valid;
    logic [N_SONARS-1:0]    r_timeout;
    logic                   r_frame_done;
    logic                   r_busy;

    logic                   w_ready_ch;
    logic [7:0]             w_sel_dist;
    logic                   w_to_hit;
    logic                   w_gap_done;
    logic                   w_last;
    logic                   w_capture;
    logic                   w_to_event;
    logic                   w_frame_end;
    logic                   w_fire_nxt;
    logic [N_SONARS-1:0]    w_onehot;

    // Selected-channel views and timer terminal counts
    assign w_ready_ch = ready[r_ch];
    assign w_sel_dist = distance[32'(r_ch) * 8 +: 8];
    assign w_to_hit   = (r_timer == TO_LAST);
    assign w_gap_done = (r_timer == GAP_LAST);
    assign w_last     = (r_ch == LAST_CH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state, channel and timer logic
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_timer_nxt = r_timer + 32'd1;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                w_ch_nxt    = '0;
                if (enable || start) w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                // Timeout is checked first so it wins over any ready activity
                if (w_to_hit) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_GAP;
                end else if (!w_ready_ch) begin
                    w_state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (w_to_hit || w_ready_ch) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_timer_nxt = '0;
                    if (w_last) begin
                        w_ch_nxt    = '0;
                        w_state_nxt = enable ? S_FIRE : S_IDLE;
                    end else begin
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_state_nxt = S_FIRE;
                    end
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_ch_nxt    = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: per-cycle events feeding the registered outputs
    always_comb begin
        w_capture   = (r_state == S_WAIT_RDY) && w_ready_ch && !w_to_hit;
        w_to_event  = ((r_state == S_WAIT_CLR) || (r_state == S_WAIT_RDY)) && w_to_hit;
        w_frame_end = (r_state == S_GAP) && w_gap_done && w_last;
        w_fire_nxt  = (w_state_nxt == S_FIRE);
        w_onehot    = N_SONARS'(1) << w_ch_nxt;
    end

    // Output registers; measure/busy/valid-clear are computed from the next state
    // so they line up with the FIRE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_measure    <= '0;
            r_dist_out   <= '0;
            r_valid      <= '0;
            r_timeout    <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_measure    <= w_fire_nxt ? w_onehot : '0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_frame_end;
            if (w_fire_nxt) begin
                r_valid[w_ch_nxt] <= 1'b0;
            end
            if (w_capture) begin
                r_dist_out[32'(r_ch) * 8 +: 8] <= w_sel_dist;
                r_valid[r_ch]                  <= 1'b1;
                r_timeout[r_ch]                <= 1'b0;
            end
            if (w_to_event) begin
                r_dist_out[32'(r_ch) * 8 +: 8] <= 8'hFF;
                r_valid[r_ch]                  <= 1'b0;
                r_timeout[r_ch]                <= 1'b1;
            end
        end
    end

    assign measure    = r_measure;
    assign dist_out   = r_dist_out;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed bench for sonar_scheduler with two behavioural
// HC-SR04 driver models (1 MHz clock, 1000-cycle gap, 2000-cycle timeout).
module tb_sonar_scheduler;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        start    = 1'b0;
    logic [1:0]  ready    = 2'b00;
    logic [15:0] distance = 16'h0000;
    logic [1:0]  measure;
    logic [15:0] dist_out;
    logic [1:0]  valid;
    logic [1:0]  timeout;
    logic        frame_done;
    logic        busy;

    sonar_scheduler #(
        .freq       (1_000_000),
        .N_SONARS   (2),
        .GAP_MS     (1),
        .TIMEOUT_MS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .measure    (measure),
        .ready      (ready),
        .distance   (distance),
        .dist_out   (dist_out),
        .valid      (valid),
        .timeout    (timeout),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Driver model configuration (written by tests, read by the model)
    int       m_delay [2] = '{300, 300};
    int       m_hold  [2] = '{0, 0};
    bit       m_dead  [2] = '{1'b0, 1'b0};
    logic [7:0] m_dist [2] = '{8'h2A, 8'h10};

    // Monitor results
    int cyc       = 0;
    int meas_cnt  = 0;
    int fd_cnt    = 0;
    int shape_err = 0;
    int order_err = 0;
    int t_meas [2] = '{0, 0};
    int t_fd      = 0;
    int t_val0    = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Behavioural driver: after a trigger, hold the old ready level for m_hold
    // cycles, drop ready, count m_delay cycles, then raise ready with the distance.
    initial begin
        int ph [2];
        int hc [2];
        int cc [2];
        ph = '{0, 0};
        hc = '{0, 0};
        cc = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (measure[i]) begin
                    hc[i] = m_hold[i];
                    cc[i] = m_delay[i];
                    ph[i] = 1;
                end else if (ph[i] == 1) begin
                    if (hc[i] > 0) hc[i] = hc[i] - 1;
                    else begin
                        ready[i]            = 1'b0;
                        distance[i*8 +: 8]  = 8'h55;
                        ph[i]               = 2;
                    end
                end else if (ph[i] == 2 && !m_dead[i]) begin
                    if (cc[i] > 0) cc[i] = cc[i] - 1;
                    else begin
                        ready[i]            = 1'b1;
                        distance[i*8 +: 8]  = m_dist[i];
                        ph[i]               = 0;
                    end
                end
            end
        end
    end

    // Output monitor: counts triggers and frames, records event cycle stamps
    initial begin
        int  last_ch;
        int  mc;
        logic pv0;
        last_ch = 1;
        pv0     = 1'b0;
        forever begin
            @(negedge clk);
            if (measure != 2'b00) begin
                meas_cnt = meas_cnt + 1;
                if ($countones(measure) != 1 || !busy) shape_err = shape_err + 1;
                else begin
                    mc = measure[1] ? 1 : 0;
                    if (mc == last_ch) order_err = order_err + 1;
                    t_meas[mc] = cyc;
                    last_ch    = mc;
                end
            end
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                t_fd   = cyc;
            end
            if (valid[0] && !pv0) t_val0 = cyc;
            pv0 = valid[0];
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (fd_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_meas(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (meas_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        wait_cycles(3);
        n_tests++; if ({measure, valid, timeout, frame_done, busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {measure, valid, timeout, frame_done, busy}); end
        n_tests++; if (dist_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dist: got %h expected 0000", dist_out); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(3);
        n_tests++; if ({measure, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 000", {measure, busy}); end
    endtask

    task automatic test_sweep();
        int m0, f0;
        bit ok;
        m0 = meas_cnt; f0 = fd_cnt;
        pulse_start();
        wait_fd(f0 + 1, 5000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL sweep_done: got no frame_done, expected one"); end
        wait_idle(50, ok);
        n_tests++; if (meas_cnt - m0 !== 2) begin
            n_fail++; $display("FAIL sweep_meas: got %0d expected 2", meas_cnt - m0); end
        n_tests++; if (t_meas[1] - t_meas[0] !== 1303) begin
            n_fail++; $display("FAIL sweep_spacing: got %0d expected 1303", t_meas[1] - t_meas[0]); end
        n_tests++; if (dist_out !== 16'h102A) begin
            n_fail++; $display("FAIL sweep_dist: got %h expected 102a", dist_out); end
        n_tests++; if ({valid, timeout} !== 4'b1100) begin
            n_fail++; $display("FAIL sweep_flags: got %b expected 1100", {valid, timeout}); end
        n_tests++; if (fd_cnt - f0 !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL sweep_end: got fd=%0d busy=%b expected fd=1 busy=0", fd_cnt - f0, busy); end
    endtask

    task automatic test_timeout();
        int f0;
        bit ok;
        f0 = fd_cnt;
        m_dead[1] = 1'b1;
        pulse_start();
        wait_fd(f0 + 1, 6000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL to_done: got no frame_done, expected one"); end
        n_tests++; if ({valid, timeout} !== 4'b0110) begin
            n_fail++; $display("FAIL to_flags: got %b expected 0110", {valid, timeout}); end
        n_tests++; if (dist_out !== 16'hFF2A) begin
            n_fail++; $display("FAIL to_dist: got %h expected ff2a", dist_out); end
        n_tests++; if (t_fd - t_meas[1] !== 3001) begin
            n_fail++; $display("FAIL to_latency: got %0d expected 3001", t_fd - t_meas[1]); end
        m_dead[1] = 1'b0;
        wait_idle(50, ok);
    endtask

    task automatic test_continuous();
        int m0, f0, s0, o0;
        bit ok;
        m0 = meas_cnt; f0 = fd_cnt; s0 = shape_err; o0 = order_err;
        @(negedge clk);
        enable = 1'b1;
        wait_fd(f0 + 3, 12000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_frames: got %0d frames, expected 3", fd_cnt - f0); end
        wait_meas(m0 + 7, 3000, ok);
        wait_cycles(50);
        enable = 1'b0;
        wait_idle(6000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_idle: got busy, expected idle"); end
        n_tests++; if (fd_cnt - f0 !== 4 || meas_cnt - m0 !== 8) begin
            n_fail++; $display("FAIL cont_counts: got fd=%0d meas=%0d expected fd=4 meas=8", fd_cnt - f0, meas_cnt - m0); end
        n_tests++; if (shape_err - s0 !== 0 || order_err - o0 !== 0) begin
            n_fail++; $display("FAIL cont_onehot: got shape=%0d order=%0d expected 0 0", shape_err - s0, order_err - o0); end
        wait_cycles(1500);
        n_tests++; if (meas_cnt - m0 !== 8 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_stays_idle: got meas=%0d busy=%b expected 8 0", meas_cnt - m0, busy); end
    endtask

    task automatic test_sticky();
        int f0;
        bit ok;
        f0 = fd_cnt;
        m_hold[0] = 40; m_delay[0] = 100; m_dist[0] = 8'h77;
        pulse_start();
        wait_fd(f0 + 1, 5000, ok);
        n_tests++; if (dist_out !== 16'h1077 || valid !== 2'b11) begin
            n_fail++; $display("FAIL sticky_dist: got %h/%b expected 1077/11", dist_out, valid); end
        n_tests++; if (t_val0 - t_meas[0] !== 143) begin
            n_fail++; $display("FAIL sticky_latency: got %0d expected 143", t_val0 - t_meas[0]); end
        m_hold[0] = 0; m_delay[0] = 300; m_dist[0] = 8'h2A;
        wait_idle(50, ok);
    endtask

    task automatic test_reset_mid();
        int m0;
        bit ok;
        m0 = meas_cnt;
        pulse_start();
        wait_meas(m0 + 2, 3000, ok);
        wait_cycles(100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({measure, valid, timeout, frame_done, busy} !== 7'b0 || dist_out !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid: got %b %h expected all zero", {measure, valid, timeout, frame_done, busy}, dist_out); end
        wait_cycles(5);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(3000);
        n_tests++; if (meas_cnt - m0 !== 2 || busy !== 1'b0 || dist_out !== 16'h0) begin
            n_fail++; $display("FAIL rst_after: got meas=%0d busy=%b dist=%h expected 2 0 0000", meas_cnt - m0, busy, dist_out); end
    endtask

    task automatic test_start_busy_to();
        int m0, f0;
        bit ok;
        m0 = meas_cnt; f0 = fd_cnt;
        m_delay[1] = 1998; m_dist[1] = 8'h33;
        pulse_start();
        wait_meas(m0 + 1, 100, ok);
        wait_cycles(10);
        pulse_start();
        wait_fd(f0 + 1, 8000, ok);
        wait_cycles(1500);
        n_tests++; if (meas_cnt - m0 !== 2 || fd_cnt - f0 !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_start: got meas=%0d fd=%0d busy=%b expected 2 1 0", meas_cnt - m0, fd_cnt - f0, busy); end
        n_tests++; if ({valid, timeout} !== 4'b0110 || dist_out !== 16'hFF2A) begin
            n_fail++; $display("FAIL to_edge: got %b %h expected 0110 ff2a", {valid, timeout}, dist_out); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_timeout();
        test_continuous();
        test_sticky();
        test_reset_mid();
        test_start_busy_to();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
